// File: rtl/mandelbrot_iter_engine.sv
// -----------------------------------------------------------------------------
// mandelbrot_iter_engine
//
// Escape-time Mandelbrot engine. It accepts one point C over a valid/ready
// handshake and iterates Z <- Z^2 + C at one iteration per clock. It returns
// the final iteration count and an escaped flag over a second valid/ready
// handshake.
//
// Optional build macro: MANDEL_JULIA_EN
//   When defined, the block adds i_julia, i_zr and i_zi. These select a
//   caller-supplied starting Z, which gives the Julia set for C.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   i_valid     new point request
//   o_ready     engine idle; request accepted when i_valid && o_ready
//   i_cr, i_ci  C, signed Q(WIDTH-FRAC).FRAC
//   i_max_iter  iteration limit, sampled at accept
//   i_julia     (MANDEL_JULIA_EN) use i_zr/i_zi as the starting Z
//   i_zr, i_zi  (MANDEL_JULIA_EN) starting Z, signed fixed point
//   o_valid     result available
//   i_ready     consumer takes the result when o_valid && i_ready
//   o_iter      final iteration count k
//   o_escaped   1 = |Z|^2 >= 4 was reached, 0 = limit was hit
//   o_busy      high while iterating
// -----------------------------------------------------------------------------
module mandelbrot_iter_engine #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WIDTH-1:0]  i_cr,
    input  logic [WIDTH-1:0]  i_ci,
    input  logic [ITER_W-1:0] i_max_iter,
`ifdef MANDEL_JULIA_EN
    input  logic              i_julia,
    input  logic [WIDTH-1:0]  i_zr,
    input  logic [WIDTH-1:0]  i_zi,
`endif
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ITER_W-1:0] o_iter,
    output logic              o_escaped,
    output logic              o_busy
);

    localparam int PW = 2*WIDTH + 1;
    // The escape threshold 4.0 sits at scale 2^(2*FRAC) in the product domain.
    localparam logic [PW-1:0] ESC_TH = {{(PW-1){1'b0}}, 1'b1} << (2*FRAC + 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITERATE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  zr_q, zr_d, zi_q, zi_d;
    logic signed [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;
    logic        [ITER_W-1:0] count_q, count_d, limit_q, limit_d;
    logic        [ITER_W-1:0] iter_q, iter_d;
    logic                     esc_q, esc_d;

    // Full-precision products. Explicit sign extension keeps each multiply at
    // 2*WIDTH bits with signed operands.
    logic signed [2*WIDTH-1:0] zr_ext, zi_ext;
    logic signed [2*WIDTH-1:0] zr2, zi2, zrzi;
    logic signed [PW-1:0]      diff_w, twoxy_w, diff_sh, twoxy_sh;
    logic        [PW-1:0]      mag_w;
    logic signed [WIDTH-1:0]   rr, ri;
    logic                      escape;

    assign zr_ext = {{WIDTH{zr_q[WIDTH-1]}}, zr_q};
    assign zi_ext = {{WIDTH{zi_q[WIDTH-1]}}, zi_q};
    assign zr2    = zr_ext * zr_ext;
    assign zi2    = zi_ext * zi_ext;
    assign zrzi   = zr_ext * zi_ext;

    // 2*Zr*Zi can reach 2^(2*WIDTH-1), so the doubled term needs one extra bit.
    assign diff_w   = {zr2[2*WIDTH-1], zr2} - {zi2[2*WIDTH-1], zi2};
    assign twoxy_w  = {zrzi, 1'b0};
    assign diff_sh  = diff_w >>> FRAC;
    assign twoxy_sh = twoxy_w >>> FRAC;

    // The next Z keeps only the low WIDTH bits. Overflow wraps by design.
    assign rr = diff_sh[WIDTH-1:0] + cr_q;
    assign ri = twoxy_sh[WIDTH-1:0] + ci_q;

    // Both squares are non-negative, so an unsigned PW-bit sum cannot overflow.
    assign mag_w  = {1'b0, zr2} + {1'b0, zi2};
    assign escape = (mag_w >= ESC_TH);

    assign o_ready   = (state_q == S_IDLE);
    assign o_busy    = (state_q == S_ITERATE);
    assign o_valid   = (state_q == S_DONE);
    assign o_iter    = iter_q;
    assign o_escaped = esc_q;

    always_comb begin
        state_d = state_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        count_d = count_q;
        limit_d = limit_q;
        iter_d  = iter_q;
        esc_d   = esc_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    cr_d    = i_cr;
                    ci_d    = i_ci;
                    limit_d = i_max_iter;
                    count_d = '0;
`ifdef MANDEL_JULIA_EN
                    zr_d    = i_julia ? i_zr : '0;
                    zi_d    = i_julia ? i_zi : '0;
`else
                    zr_d    = '0;
                    zi_d    = '0;
`endif
                    state_d = S_ITERATE;
                end
            end
            S_ITERATE: begin
                // The escape test takes priority over the limit, which takes
                // priority over the update. This means count never passes limit.
                if (escape) begin
                    iter_d  = count_q;
                    esc_d   = 1'b1;
                    state_d = S_DONE;
                end else if (count_q == limit_q) begin
                    iter_d  = count_q;
                    esc_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    zr_d    = rr;
                    zi_d    = ri;
                    count_d = count_q + ITER_W'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            zr_q    <= '0;
            zi_q    <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            count_q <= '0;
            limit_q <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            count_q <= count_d;
            limit_q <= limit_d;
            iter_q  <= iter_d;
            esc_q   <= esc_d;
        end
    end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// -----------------------------------------------------------------------------
// tb_mandelbrot_iter_engine
//
// Self-checking bench for mandelbrot_iter_engine. It uses the default
// parameters (1.0 = 0x01000000). Expected count, escape flag and latency come
// from an escape-time reference model computed in wide integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mandelbrot_iter_engine;

    localparam int WIDTH  = 32;
    localparam int FRAC   = 24;
    localparam int ITER_W = 8;
    localparam logic signed [31:0] ONE = 32'sh0100_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [WIDTH-1:0]  i_cr, i_ci;
    logic [ITER_W-1:0] i_max_iter;
    logic              o_valid;
    logic              i_ready;
    logic [ITER_W-1:0] o_iter;
    logic              o_escaped;
    logic              o_busy;
`ifdef MANDEL_JULIA_EN
    logic              i_julia;
    logic [WIDTH-1:0]  i_zr, i_zi;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_cr       (i_cr),
        .i_ci       (i_ci),
        .i_max_iter (i_max_iter),
`ifdef MANDEL_JULIA_EN
        .i_julia    (i_julia),
        .i_zr       (i_zr),
        .i_zi       (i_zi),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_iter     (o_iter),
        .o_escaped  (o_escaped),
        .o_busy     (o_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the escape-time recurrence, computed in 66-bit math.
    task automatic ref_model(input logic signed [31:0] cr, input logic signed [31:0] ci,
                             input logic signed [31:0] z0r, input logic signed [31:0] z0i,
                             input int maxi, output int k, output bit esc);
        logic signed [31:0] zr, zi;
        logic signed [65:0] a, b, sq_r, sq_i, xy, nr, ni;
        zr = z0r;
        zi = z0i;
        k  = 0;
        esc = 1'b0;
        forever begin
            a    = zr;
            b    = zi;
            sq_r = a * a;
            sq_i = b * b;
            xy   = 2 * a * b;
            if (sq_r + sq_i >= (66'sd4 <<< (2*FRAC))) begin
                esc = 1'b1;
                break;
            end
            if (k == maxi) break;
            nr = ((sq_r - sq_i) >>> FRAC) + cr;
            ni = (xy >>> FRAC) + ci;
            zr = nr[31:0];
            zi = ni[31:0];
            k++;
        end
    endtask

    // Issue one point and check the busy phase, latency, result and release.
    // hold > 0 keeps i_ready low for that many cycles in DONE while new
    // requests are pulsed at the engine.
    task automatic run_point(input string tag, input logic signed [31:0] cr,
                             input logic signed [31:0] ci, input int mx,
                             input bit julia, input logic signed [31:0] z0r,
                             input logic signed [31:0] z0i, input int hold);
        int  k_exp;
        bit  e_exp;
        int  cyc;
        logic [ITER_W-1:0] it_seen;
        logic              es_seen;
        if (julia) ref_model(cr, ci, z0r, z0i, mx, k_exp, e_exp);
        else       ref_model(cr, ci, 32'sd0, 32'sd0, mx, k_exp, e_exp);
        @(negedge clk);
        check_eq({tag, ":ready_before"}, 64'(o_ready), 64'd1);
        i_valid    = 1'b1;
        i_cr       = cr;
        i_ci       = ci;
        i_max_iter = ITER_W'(mx);
        i_ready    = (hold == 0);
`ifdef MANDEL_JULIA_EN
        i_julia = julia;
        i_zr    = z0r;
        i_zi    = z0i;
`endif
        @(negedge clk);
        i_valid = 1'b0;
        check_eq({tag, ":busy"}, 64'(o_busy), 64'd1);
        check_eq({tag, ":ready_busy"}, 64'(o_ready), 64'd0);
        cyc = 0;
        while (!o_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, ":latency"}, 64'(cyc), 64'(k_exp + 1));
        check_eq({tag, ":iter"}, 64'(o_iter), 64'(k_exp));
        check_eq({tag, ":escaped"}, 64'(o_escaped), 64'(e_exp));
        check_eq({tag, ":busy_done"}, 64'(o_busy), 64'd0);
        it_seen = o_iter;
        es_seen = o_escaped;
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            i_cr    = 32'($urandom);
            i_ci    = 32'($urandom);
            @(negedge clk);
            check_eq({tag, ":hold_valid"}, 64'(o_valid), 64'd1);
            check_eq({tag, ":hold_iter"}, 64'(o_iter), 64'(it_seen));
            check_eq({tag, ":hold_esc"}, 64'(o_escaped), 64'(es_seen));
            check_eq({tag, ":hold_ready"}, 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        if (hold > 0) @(negedge clk);
        @(negedge clk);
        check_eq({tag, ":ready_after"}, 64'(o_ready), 64'd1);
        check_eq({tag, ":valid_after"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        logic signed [31:0] rc, ic;
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_cr       = '0;
        i_ci       = '0;
        i_max_iter = '0;
`ifdef MANDEL_JULIA_EN
        i_julia = 1'b0;
        i_zr    = '0;
        i_zi    = '0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst:ready", 64'(o_ready), 64'd1);
        check_eq("rst:valid", 64'(o_valid), 64'd0);
        check_eq("rst:busy", 64'(o_busy), 64'd0);
        check_eq("rst:iter", 64'(o_iter), 64'd0);
        check_eq("rst:esc", 64'(o_escaped), 64'd0);
        rst = 1'b0;

        run_point("c00",   32'sd0, 32'sd0, 50, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("c10",   ONE, 32'sd0, 50, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("cm20",  -2 * ONE, 32'sd0, 50, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("c0i",   32'sd0, ONE, 100, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("c05",   ONE / 2, 32'sd0, 20, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("lim0",  ONE + ONE / 2, ONE + ONE / 2, 0, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("lim255", -ONE, 32'sd0, 255, 1'b0, 32'sd0, 32'sd0, 0);
        run_point("bp",    ONE, 32'sd0, 50, 1'b0, 32'sd0, 32'sd0, 10);

        // Reset mid-iteration discards the computation.
        @(negedge clk);
        i_valid    = 1'b1;
        i_cr       = '0;
        i_ci       = '0;
        i_max_iter = 8'd200;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("midrst:busy_before", 64'(o_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst:valid", 64'(o_valid), 64'd0);
        check_eq("midrst:busy", 64'(o_busy), 64'd0);
        check_eq("midrst:ready", 64'(o_ready), 64'd1);
        check_eq("midrst:iter", 64'(o_iter), 64'd0);
        check_eq("midrst:esc", 64'(o_escaped), 64'd0);
        run_point("after_rst", ONE / 4, ONE / 2, 30, 1'b0, 32'sd0, 32'sd0, 0);

`ifdef MANDEL_JULIA_EN
        run_point("julia_out", 32'sd0, 32'sd0, 50, 1'b1, 2 * ONE, ONE / 2, 0);
        run_point("julia_in",  -ONE / 2, ONE / 4, 40, 1'b1, ONE / 4, -ONE / 8, 0);
`endif

        // Random points near the set, plus full-range points that exercise wrap.
        for (int n = 0; n < 40; n++) begin
            rc = $signed(32'($urandom_range(0, 32'h0500_0000))) - 32'sh0280_0000;
            ic = $signed(32'($urandom_range(0, 32'h0300_0000))) - 32'sh0180_0000;
            run_point("rnd", rc, ic, int'($urandom_range(0, 60)), 1'b0, 32'sd0, 32'sd0,
                      (n % 8 == 3) ? 3 : 0);
        end
        for (int n = 0; n < 10; n++) begin
            run_point("rndw", 32'($urandom), 32'($urandom), int'($urandom_range(0, 255)),
                      1'b0, 32'sd0, 32'sd0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
